dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored; power of two, at least 4.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning stall cycles per access; 1 to 15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 MemReadM  input  1  M-stage load request.
REQ-007 MemWriteM  input  1  M-stage store request.
REQ-008 ALUOutM  input  32  byte address of the access.
REQ-009 WriteDataM  input  32  store data.
REQ-010 ReadDataM  output  32  load data; registered.
REQ-011 MemStallM  output  1  to hazard unit; freezes stages F through M while high.
REQ-012 MemErrM  output  1  sticky misaligned-access flag; registered.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 IDLE with MemReadM or MemWriteM high SHALL latch op, address and data, load the counter with LATENCY-1, and go to BUSY; if LATENCY=1 it SHALL go directly to DONE.
REQ-015 BUSY SHALL decrement the counter each cycle and go to DONE on the cycle the counter equals 0.
REQ-016 DONE SHALL return to IDLE unconditionally; a request present in DONE is not accepted as a new access.
REQ-017 MemStallM SHALL be combinational: high in IDLE while a request is present, and high throughout BUSY; low in DONE and while reset is high.
REQ-018 For a request first seen in IDLE at cycle t, MemStallM SHALL be high for cycles t through t+LATENCY-1 exactly, and the state SHALL be DONE at t+LATENCY.
REQ-019 A store SHALL write the array on the clock edge entering DONE.
REQ-020 A load SHALL register array data into ReadDataM on the clock edge entering DONE; ReadDataM SHALL hold until the next completed load.
REQ-021 The word index SHALL be ALUOutM[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-022 If ALUOutM[1:0] is not 0, the access SHALL complete with normal timing, SHALL NOT write, SHALL return ReadDataM=0 for a load, and SHALL set MemErrM.
REQ-023 MemErrM SHALL stay set until reset.
REQ-024 If MemReadM and MemWriteM are both high, the access SHALL be treated as a store, and ReadDataM SHALL be unchanged.
REQ-025 Inputs that change during BUSY SHALL be ignored, because the latched copies are used.

Reset
REQ-026 Reset SHALL force state IDLE and counter 0, with ReadDataM=0, MemStallM=0 and MemErrM=0.
REQ-027 Reset during BUSY SHALL abort the access without writing the array.
REQ-028 Array contents SHALL NOT be cleared by reset.

Structure
REQ-029 The state enum and the default DEPTH and LATENCY constants SHALL reside in the shared pipeline package.
REQ-030 The storage SHALL be a single sub-module, dmem_array.
- one write port and one read port, both synchronous
- ports: clk, we, index, wdata, rdata
REQ-031 The FSM, counter and error logic SHALL reside in dmem_responder.

Verification
REQ-032 With LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10.
- MemStallM high for 2 cycles per access
- ReadDataM=0xDEADBEEF on the cycle after DONE
REQ-033 With LATENCY=1: back-to-back loads.
- each load stalls exactly 1 cycle
- DONE to IDLE gap: no request is lost and none is repeated
REQ-034 Store 0x12345678 to 0x00, then load from address 4*DEPTH.
- ReadDataM=0x12345678 (wrap)
REQ-035 Store to 0x13.
- array is unchanged
- MemErrM=1 and remains 1 through later valid accesses until reset
REQ-036 Assert reset in BUSY during a store of 0xCAFEF00D to 0x20.
- next cycle: MemStallM=0 and state IDLE
- a later load of 0x20 returns the prior contents
REQ-037 MemReadM and MemWriteM both high with WriteDataM=0x5 at 0x8.
- store performed
- ReadDataM unchanged
- a subsequent load of 0x8 returns 0x5

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// default geometry/timing constants.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT   = 1024;
    localparam int unsigned DMEM_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data memory: one synchronous write port and
// one synchronous read port; contents are never cleared.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] index,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
        rdata <= mem_q[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage: stalls the pipeline for
// LATENCY cycles per access and flags misaligned accesses.
//
// state | meaning
// IDLE  | waiting; a load/store request is accepted and latched here
// BUSY  | access in flight, counter running down
// DONE  | access completed this edge; requests are not accepted
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemErrM
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_e   state_q;
    logic [3:0]    cnt_q;
    logic          op_rd_q, op_wr_q;
    logic [IW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   hold_q;
    logic          rd_sel_q;
    logic          err_q;

    logic          req, in_idle, go_done;
    logic          cur_rd, cur_wr, cur_ok, cur_load;
    logic [IW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic          arr_we;
    logic [31:0]   arr_rdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^ALUOutM[31:IW+2];

    assign req     = MemReadM | MemWriteM;
    assign in_idle = (state_q == IDLE);

    // With LATENCY=1 the access completes straight out of IDLE, so the live
    // inputs must feed the array on that edge instead of the latched copies.
    assign cur_rd    = in_idle ? MemReadM           : op_rd_q;
    assign cur_wr    = in_idle ? MemWriteM          : op_wr_q;
    assign cur_addr  = in_idle ? ALUOutM[IW+1:0]    : addr_q;
    assign cur_wdata = in_idle ? WriteDataM         : wdata_q;
    assign cur_ok    = (cur_addr[1:0] == 2'b00);
    assign cur_load  = cur_rd & ~cur_wr;

    assign go_done = (in_idle && req && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd1));

    assign arr_we    = ~reset & go_done & cur_wr & cur_ok;
    assign MemStallM = ~reset & ((in_idle & req) | (state_q == BUSY));
    assign MemErrM   = err_q;

    // The array read register carries load data during DONE; hold_q keeps it afterwards.
    assign ReadDataM = rd_sel_q ? arr_rdata : hold_q;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (cur_addr[IW+1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_rd_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            hold_q   <= 32'd0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_sel_q <= go_done & cur_load & cur_ok;
            if (rd_sel_q) begin
                hold_q <= arr_rdata;
            end else if (go_done & cur_load & ~cur_ok) begin
                hold_q <= 32'd0;
            end
            if (go_done & ~cur_ok) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_rd_q <= MemReadM;
                        op_wr_q <= MemWriteM;
                        addr_q  <= ALUOutM[IW+1:0];
                        wdata_q <= WriteDataM;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
